ahb3lite_sdram_arb: RTL
=======================

// Module: ahb3lite_sdram_arb
// PURPOSE
//  Schedules access to the single SDRAM command engine. It arbitrates round-robin
//  between the AHB_PORTS data ports. It also owns the auto-refresh interval timer and
//  its postponed-refresh credit counter. It sits between the per-port AHB front-ends
//  and the SDRAM command/timing engine, and is clocked in the AHB clock domain.
// PARAMETERS
//  AHB_PORTS     1   number of AHB requesters (1..16)
//  TREF_SIZE     16  width of refresh-interval count
//  MAX_POSTPONE  8   max refresh credits (JEDEC postpone limit, 1..8)
// PORTS
//  HCLK           in   1             clock
//  HRESETn        in   1             asynchronous active-low reset
//  enable_i       in   1             SDRAM init done; arbitration/refresh enabled
//  tref_i         in   TREF_SIZE     refresh interval in HCLK cycles (CSR); 0=timer off
//  port_req_i     in   AHB_PORTS     per-port access request, level, held until granted
//  port_lock_i    in   AHB_PORTS     per-port HMASTLOCK qualifier
//  done_i         in   1             1-cycle pulse: engine finished current grant
//  grant_o        out  AHB_PORTS     one-hot port grant, registered
//  grant_ref_o    out  1             refresh granted, registered
//  busy_o         out  1             any grant active
//  ref_credits_o  out  4             pending refresh credits
//  ref_overflow_o out  1             sticky: refresh tick lost at MAX_POSTPONE
// BEHAVIOUR
//  Reset: grant_o=0, grant_ref_o=0, busy_o=0, ref_credits_o=0, ref_overflow_o=0.
//  Reset: timer=0, last-port pointer=AHB_PORTS-1, state IDLE.
//  Timer
//   - enable_i=0 or tref_i=0: timer loads tref_i; credits held at 0; no ticks.
//   - Otherwise the timer decrements each cycle. At 1 it emits a tick and reloads tref_i.
//     Tick interval is therefore exactly tref_i cycles.
//   - A tick increments credits, saturating at MAX_POSTPONE.
//   - A tick while at max sets ref_overflow_o. Only reset clears it.
//  Credits decrement on done_i in REFRESH.
//   - Tick and refresh-done in the same cycle: net unchanged.
//  States
//   IDLE    (busy_o=0). Evaluated every cycle with enable_i=1, priority order:
//     1. credits==MAX_POSTPONE -> REFRESH (urgent).
//     2. any port_req_i -> PORT. Winner is the first requesting port after the
//        last-port pointer, searching upward mod AHB_PORTS. The pointer updates to the winner.
//     3. credits>0 -> REFRESH (opportunistic).
//     4. otherwise stay in IDLE.
//   PORT    grant_o one-hot, held until done_i.
//     On done_i with port_lock_i of the granted port=1, port_req_i still=1 and
//     credits<MAX_POSTPONE: stay in PORT with the same grant (locked sequence).
//     Otherwise -> IDLE.
//   REFRESH grant_ref_o=1 until done_i -> IDLE.
//  Latency: request seen in IDLE at edge N -> grant visible after edge N+1.
//  Minimum one IDLE cycle between unlocked grants. grant_o and grant_ref_o are never both set.
//  done_i in IDLE is ignored.
//  enable_i falling mid-grant: the current grant completes normally, then no new grants.
//  Credits clear the cycle enable_i=0.
//  Reset mid-grant: all outputs drop asynchronously. No state is retained.
//  port_req_i dropped before grant: no grant is issued to that port.
// TESTING
//  1. tref_i=100, no requests, done_i 4 cycles after each grant_ref_o
//     -> grant_ref_o every 100 cycles, credits 1->0, overflow=0.
//  2. AHB_PORTS=4, all req held, done_i 2 cycles after each grant
//     -> grant order 0,1,2,3,0 with no port starved.
//  3. Port 1 req+lock, 3 done_i pulses
//     -> grant_o stays 4'b0010 across all three, with no IDLE gap.
//  4. Port 0 holds grant 900 cycles, tref_i=100
//     -> credits reach 8; at 9th tick overflow=1. On done_i, REFRESH wins
//     over a pending port request.
//  5. Tick coincident with refresh done_i at credits=3 -> credits stay 3.
//  6. HRESETn asserted while grant_o=4'b0100 -> all outputs 0 at once.
//     After release, port 0 is first winner.

Source files
------------

// File: rtl/ahb3lite_sdram_arb.sv
// ---------------------------------------------------------------------------
// ahb3lite_sdram_arb
//   Grants the single SDRAM command engine either to one of AHB_PORTS AHB
//   front-ends (round-robin) or to an auto-refresh cycle. Also owns the
//   refresh interval timer and the postponed-refresh credit counter.
//
// Handshake: a requester raises port_req_i and holds it (level) until it sees
//   its grant_o bit; the engine works on the granted port/refresh and pulses
//   done_i for one cycle when finished. Grants are registered and held until
//   that done_i; done_i while nothing is granted is ignored.
//
// Ports
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   enable_i        SDRAM init done; enables arbitration and refresh timer
//   tref_i          refresh interval in HCLK cycles, 0 disables the timer
//   port_req_i      per-port request level
//   port_lock_i     per-port HMASTLOCK qualifier (keeps a grant across done_i)
//   done_i          engine finished the current grant (1-cycle pulse)
//   grant_o         one-hot port grant
//   grant_ref_o     refresh grant
//   busy_o          any grant active
//   ref_credits_o   pending refresh credits
//   ref_overflow_o  sticky: a refresh tick was lost at MAX_POSTPONE credits
// ---------------------------------------------------------------------------
module ahb3lite_sdram_arb #(
  parameter int AHB_PORTS    = 1,
  parameter int TREF_SIZE    = 16,
  parameter int MAX_POSTPONE = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 enable_i,
  input  logic [TREF_SIZE-1:0] tref_i,
  input  logic [AHB_PORTS-1:0] port_req_i,
  input  logic [AHB_PORTS-1:0] port_lock_i,
  input  logic                 done_i,
  output logic [AHB_PORTS-1:0] grant_o,
  output logic                 grant_ref_o,
  output logic                 busy_o,
  output logic [3:0]           ref_credits_o,
  output logic                 ref_overflow_o
);

  localparam int                   PTR_W     = (AHB_PORTS > 1) ? $clog2(AHB_PORTS) : 1;
  localparam logic [3:0]           CRED_MAX  = 4'(MAX_POSTPONE);
  localparam logic [PTR_W-1:0]     PTR_RST   = PTR_W'(AHB_PORTS - 1);
  localparam logic [TREF_SIZE-1:0] TIMER_ONE = TREF_SIZE'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PORT    = 2'd1,
    ST_REFRESH = 2'd2
  } state_t;

  // state_q is the FSM state register; checkers can bind to it directly.
  state_t                 state_q, state_n;
  logic [AHB_PORTS-1:0]   grant_q, grant_n;
  logic                   grant_ref_q, grant_ref_n;
  logic [PTR_W-1:0]       ptr_q, ptr_n;
  logic [TREF_SIZE-1:0]   timer_q;
  logic [3:0]             credits_q;
  logic                   overflow_q;

  logic                   timer_run;
  logic                   ref_tick;
  logic                   ref_done;
  logic                   win_found;
  logic [PTR_W-1:0]       win_idx;
  logic [PTR_W-1:0]       cand;
  logic [AHB_PORTS-1:0]   win_onehot;
  logic                   lock_keep;

  // -------------------------------------------------------------------------
  // Refresh interval timer. Counts tref_i..1; the tick happens on the cycle
  // the count is 1, so ticks are exactly tref_i cycles apart. A zero count
  // (only possible straight after reset) just reloads.
  // -------------------------------------------------------------------------
  assign timer_run = enable_i && (tref_i != '0);
  assign ref_tick  = timer_run && (timer_q == TIMER_ONE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      timer_q <= '0;
    end else if (!timer_run || timer_q == '0 || timer_q == TIMER_ONE) begin
      timer_q <= tref_i;
    end else begin
      timer_q <= timer_q - TIMER_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // Refresh credits. A tick and a completed refresh in the same cycle cancel.
  // A tick at full credits is lost and flagged (sticky until reset).
  // -------------------------------------------------------------------------
  assign ref_done = done_i && (state_q == ST_REFRESH);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      credits_q  <= '0;
      overflow_q <= 1'b0;
    end else if (!enable_i) begin
      credits_q <= '0;
    end else if (ref_tick && !ref_done) begin
      if (credits_q == CRED_MAX) begin
        overflow_q <= 1'b1;
      end else begin
        credits_q <= credits_q + 4'd1;
      end
    end else if (ref_done && !ref_tick && credits_q != '0) begin
      // credits can already be 0 here if enable_i dropped mid-refresh
      credits_q <= credits_q - 4'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin winner: first requester strictly after the last winner.
  // -------------------------------------------------------------------------
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    cand       = '0;
    win_onehot = '0;
    for (int i = 1; i <= AHB_PORTS; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % AHB_PORTS);
      if (!win_found && port_req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_onehot[win_idx] = 1'b1;
  end

  // A locked port keeps the engine across done_i unless refresh has become
  // urgent; a disabled arbiter never extends a grant.
  assign lock_keep = enable_i
                  && |(port_lock_i & grant_q)
                  && |(port_req_i & grant_q)
                  && (credits_q < CRED_MAX);

  // -------------------------------------------------------------------------
  // Arbitration FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_n     = state_q;
    grant_n     = grant_q;
    grant_ref_n = grant_ref_q;
    ptr_n       = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          if (credits_q == CRED_MAX) begin
            state_n     = ST_REFRESH;
            grant_ref_n = 1'b1;
          end else if (win_found) begin
            state_n = ST_PORT;
            grant_n = win_onehot;
            ptr_n   = win_idx;
          end else if (credits_q != '0) begin
            state_n     = ST_REFRESH;
            grant_ref_n = 1'b1;
          end
        end
      end
      ST_PORT: begin
        if (done_i && !lock_keep) begin
          state_n = ST_IDLE;
          grant_n = '0;
        end
      end
      ST_REFRESH: begin
        if (done_i) begin
          state_n     = ST_IDLE;
          grant_ref_n = 1'b0;
        end
      end
      default: begin
        state_n     = ST_IDLE;
        grant_n     = '0;
        grant_ref_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      grant_ref_q <= 1'b0;
      ptr_q       <= PTR_RST;
    end else begin
      state_q     <= state_n;
      grant_q     <= grant_n;
      grant_ref_q <= grant_ref_n;
      ptr_q       <= ptr_n;
    end
  end

  assign grant_o        = grant_q;
  assign grant_ref_o    = grant_ref_q;
  assign busy_o         = (|grant_q) | grant_ref_q;
  assign ref_credits_o  = credits_q;
  assign ref_overflow_o = overflow_q;

endmodule
